// File: rtl/phase_array_writer_pkg.sv
// phase_array_writer_pkg: shared enums, divisor constant and phase thresholds.
package phase_array_writer_pkg;
  typedef enum logic [1:0] {P0, P1, P2, P3} phase_e;
  typedef enum logic {IDLE, CLEAR} state_e;
  localparam int MOD_DIVISOR = 5;
  function automatic logic [31:0] p2_start(input int cnt_w);
    return 32'(1) << (cnt_w - 1);
  endfunction
  function automatic logic [31:0] p3_start(input int cnt_w);
    return 32'(3) << (cnt_w - 2);
  endfunction
  function automatic phase_e phase_of(input logic [31:0] cnt, input int cnt_w);
    return cnt == 0 ? P0 : cnt < p2_start(cnt_w) ? P1 : cnt < p3_start(cnt_w) ? P2 : P3;
  endfunction
endpackage

// File: rtl/phase_array_writer_alu.sv
// phase_array_writer_alu: combinational per-phase transform of a sample.
import phase_array_writer_pkg::*;
module phase_array_writer_alu #(
  parameter int WIDTH = 32
) (
  input  phase_e             phase,
  input  logic [WIDTH-1:0]   value,
  output logic [WIDTH-1:0]   result
);
  always_comb
    result = phase == P0 ? value % WIDTH'(MOD_DIVISOR) :
             phase == P1 ? value >> 1 :
             phase == P2 ? value >> 2 : '0;
endmodule

// File: rtl/phase_array_writer.sv
// phase_array_writer: two-stage sample writer into a small array with a sequential clear.
// Define PHASE_ARRAY_WRITER_CNT_SAT_EN to make the sample counter saturate instead of wrap.
import phase_array_writer_pkg::*;
module phase_array_writer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             wr_valid,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic [CNT_W-1:0] cnt_o,
  output logic             busy
);
  state_e state, state_n;
  logic [AW-1:0] addr, s1_addr, wr_a;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [WIDTH-1:0] s1_data, alu_out, wr_d;
  logic [WIDTH-1:0] mem [DEPTH];
  phase_e s1_phase;
  logic s1_valid, xfer, last, wr_en;
  phase_array_writer_alu #(.WIDTH(WIDTH)) u_alu (.phase(s1_phase), .value(s1_data), .result(alu_out));
`ifdef PHASE_ARRAY_WRITER_CNT_SAT_EN
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
`else
  assign cnt_inc = cnt + 1'b1;
`endif
  assign in_ready = state == IDLE && !clr_i;
  assign xfer = in_valid && in_ready;
  assign busy = state == CLEAR;
  assign last = addr == AW'(DEPTH - 1);
  assign rd_data = mem[rd_addr];
  assign cnt_o = cnt;
  // In CLEAR, addr doubles as the clear index; stage 1 is always empty then.
  assign wr_en = s1_valid || busy;
  assign wr_a = busy ? addr : s1_addr;
  assign wr_d = busy ? '0 : alu_out;
  always_comb
    state_n = state == IDLE ? (clr_i ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr <= '0;
      cnt <= '0;
      s1_valid <= 1'b0;
      s1_addr <= '0;
      s1_data <= '0;
      s1_phase <= P0;
      wr_valid <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_data <= in_data;
        s1_addr <= addr;
        s1_phase <= phase_of(32'(cnt), CNT_W);
        addr <= addr + 1'b1;
        cnt <= cnt_inc;
      end
      if (state == IDLE && clr_i) addr <= '0;
      if (busy) begin
        addr <= addr + 1'b1;
        if (last) cnt <= '0;
      end
      wr_valid <= wr_en;
      wr_addr <= wr_a;
      wr_data <= wr_d;
      if (wr_en) mem[wr_a] <= wr_d;
    end
  end
endmodule

// File: tb/tb_phase_array_writer.sv
// tb_phase_array_writer: directed stimulus with a per-cycle reference model and literal spot checks.
module tb_phase_array_writer;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic clr_i = 1'b0, in_valid = 1'b0, in_ready, wr_valid, busy;
  logic [31:0] in_data = '0, rd_data, wr_data;
  logic [1:0] rd_addr = '0, wr_addr;
  logic [7:0] cnt_o;
  int checks = 0, failures = 0;

  phase_array_writer dut (
    .clk(clk), .reset_n(reset_n), .clr_i(clr_i), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .rd_addr(rd_addr), .rd_data(rd_data), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .cnt_o(cnt_o), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: what each accepted sample must write, and where.
  logic [31:0] m_mem [4];
  logic [31:0] p_d = '0, e_wd = '0;
  int m_addr = 0, m_cnt = 0, m_idx = 0, p_a = 0, e_wa = 0;
  bit m_clear = 0, p_v = 0, e_wv = 0;

  function automatic logic [31:0] expect_val(input logic [31:0] v, input int c);
    if (c == 0) return v % 5;
    if (c < 128) return v / 2;
    if (c < 192) return v / 4;
    return 0;
  endfunction

  function automatic int next_cnt(input int c);
`ifdef PHASE_ARRAY_WRITER_CNT_SAT_EN
    return c == 255 ? 255 : c + 1;
`else
    return (c + 1) % 256;
`endif
  endfunction

  initial foreach (m_mem[i]) m_mem[i] = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_clear = 0; m_idx = 0; m_addr = 0; m_cnt = 0; p_v = 0;
      e_wv = 0; e_wa = 0; e_wd = '0;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else begin
      e_wv = 0;
      if (p_v) begin
        m_mem[p_a] = p_d; e_wv = 1; e_wa = p_a; e_wd = p_d;
      end
      p_v = 0;
      if (m_clear) begin
        m_mem[m_idx] = '0; e_wv = 1; e_wa = m_idx; e_wd = '0;
        m_idx++;
        if (m_idx == 4) begin m_clear = 0; m_addr = 0; m_cnt = 0; end
      end else if (clr_i) begin
        m_clear = 1; m_idx = 0;
      end else if (in_valid) begin
        p_v = 1; p_a = m_addr; p_d = expect_val(in_data, m_cnt);
        m_addr = (m_addr + 1) % 4;
        m_cnt = next_cnt(m_cnt);
      end
    end
  end

  always @(negedge clk) begin
    chk("wr_valid", 64'(wr_valid), 64'(e_wv));
    if (e_wv) begin
      chk("wr_addr", 64'(wr_addr), 64'(e_wa));
      chk("wr_data", 64'(wr_data), 64'(e_wd));
    end
    chk("cnt_o", 64'(cnt_o), 64'(m_cnt));
    chk("busy", 64'(busy), 64'(m_clear));
    chk("in_ready", 64'(in_ready), 64'(!m_clear && !clr_i));
    chk("rd_data", 64'(rd_data), 64'(m_mem[rd_addr]));
  end

  task automatic step(input logic v, input logic [31:0] d, input logic c);
    in_valid = v; in_data = d; clr_i = c;
    @(posedge clk); #1;
  endtask

  task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    rd_addr = a; #1;
    chk(name, 64'(rd_data), 64'(exp));
  endtask

  initial begin
    #2 reset_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) read_chk("reset_rd", 2'(i), 32'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_wr_valid", 64'(wr_valid), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("ready_after_reset", 64'(in_ready), 64'd1);
    step(1, 32'd23, 0);
    step(0, 32'd0, 0);
    chk("first_wr_valid", 64'(wr_valid), 64'd1);
    chk("first_wr_addr", 64'(wr_addr), 64'd0);
    chk("first_wr_data", 64'(wr_data), 64'd3);
    read_chk("first_rd", 2'd0, 32'd3);
    chk("first_cnt", 64'(cnt_o), 64'd1);
    step(1, 32'd100, 0);
    step(1, 32'd7, 0);
    chk("b2b_wr0", 64'({wr_valid, wr_data}), {32'd0, 1'b1, 32'd50});
    step(1, 32'd9, 0);
    chk("b2b_wr1", 64'({wr_valid, wr_data}), {32'd0, 1'b1, 32'd3});
    step(0, 32'd0, 0);
    chk("b2b_wr2", 64'({wr_valid, wr_data}), {32'd0, 1'b1, 32'd4});
    read_chk("entry1", 2'd1, 32'd50);
    read_chk("entry2", 2'd2, 32'd3);
    read_chk("entry3", 2'd3, 32'd4);
    step(1, 32'd10, 0);
    step(0, 32'd0, 0);
    chk("wrap_addr", 64'(wr_addr), 64'd0);
    read_chk("wrap_entry0", 2'd0, 32'd5);
    in_valid = 1'b1; clr_i = 1'b1; #1;
    chk("clr_blocks_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; clr_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("clr_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
      chk("clr_wr", 64'({wr_valid, wr_addr, wr_data}), 64'({1'b1, 2'(i), 32'd0}));
    end
    chk("clr_done_busy", 64'(busy), 64'd0);
    chk("clr_done_cnt", 64'(cnt_o), 64'd0);
    chk("clr_done_ready", 64'(in_ready), 64'd1);
    read_chk("clr_entry0", 2'd0, 32'd0);
    for (int i = 0; i < 256; i++) begin
      step(1, 32'hFFFF_FFFF, 0);
      if (i == 1) chk("p0_ones", 64'(wr_data), 64'd0);
      if (i == 2) chk("p1_ones", 64'(wr_data), 64'h7FFF_FFFF);
      if (i == 129) chk("p2_start", 64'(wr_data), 64'h3FFF_FFFF);
      if (i == 193) chk("p3_start", 64'(wr_data), 64'd0);
    end
    step(0, 32'd0, 0);
`ifdef PHASE_ARRAY_WRITER_CNT_SAT_EN
    chk("cnt_256", 64'(cnt_o), 64'd255);
`else
    chk("cnt_256", 64'(cnt_o), 64'd0);
`endif
    step(1, 32'd12, 0);
    step(0, 32'd0, 0);
`ifdef PHASE_ARRAY_WRITER_CNT_SAT_EN
    chk("after_256", 64'(wr_data), 64'd0);
`else
    chk("after_256", 64'(wr_data), 64'd2);
`endif
    step(1, 32'd50, 0);
    step(1, 32'd60, 0);
    step(1, 32'd70, 0);
    step(0, 32'd0, 0);
    step(0, 32'd0, 1);
    clr_i = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0; #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_wr_valid", 64'(wr_valid), 64'd0);
    for (int i = 0; i < 4; i++) read_chk("abort_rd", 2'(i), 32'd0);
    @(posedge clk); #1;
    chk("abort_hold_wr", 64'(wr_valid), 64'd0);
    reset_n = 1'b1;
    chk("abort_ready", 64'(in_ready), 64'd1);
    step(1, 32'd40, 0);
    step(0, 32'd0, 0);
    chk("post_abort_wr", 64'({wr_valid, wr_addr, wr_data}), 64'({1'b1, 2'd0, 32'd0}));
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
